// File: rtl/spi_mem_pkg.sv
// Shared types and counter widths for the SPI memory port arbiter.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    typedef logic port_idx_t;

    localparam int unsigned DW      = 8;
    localparam int unsigned GAP_MAX = 15;
    localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
    localparam int unsigned TO_MAX  = 65535;
    localparam int unsigned TO_W    = $clog2(TO_MAX + 1);

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// mem_* style bus between a requester (master) and a memory port (slave).
interface spi_mem_arbiter_if
    import spi_mem_pkg::*;
#(
    parameter int unsigned AW = 24
);
    logic [AW-1:0] addr;
    logic          en;
    logic          wr;
    logic          rburst;
    logic          wburst;
    logic [DW-1:0] wdata;
    logic          rdy;
    logic          rdata_load;
    logic [DW-1:0] rdata;
    logic [DW-1:0] rdata0;

    modport master (
        output addr, en, wr, rburst, wburst, wdata,
        input  rdy, rdata_load, rdata, rdata0
    );

    modport slave (
        input  addr, en, wr, rburst, wburst, wdata,
        output rdy, rdata_load, rdata, rdata0
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-request picker: round-robin against the last owner, or fixed port-0 priority.
module rr_pick2
    import spi_mem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  port_idx_t  last,
    output port_idx_t  pick_c,
    output logic       any_c
);

    always_comb begin
        any_c  = |req;
        pick_c = port_idx_t'(req[1] && !req[0]);
        if (req == 2'b11) begin
            pick_c = FIXED_PRIO ? port_idx_t'(1'b0) : port_idx_t'(!last);
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI SRAM master port between two requesters; grants span whole
// transactions and are followed by a forced idle gap so the master can drop cs_n.
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int unsigned AW         = 24,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_mem_arbiter_if.slave  p0,
    spi_mem_arbiter_if.slave  p1,
    spi_mem_arbiter_if.master mem,
    output logic [1:0]        gnt,
    output logic              timeout_err
);

    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);
    localparam bit               TO_ENABLE = (TIMEOUT != 0);

    arb_state_t       state, state_d;
    port_idx_t        last, last_d, own_idx_c, pick_c;
    logic [GAP_W-1:0] gap_cnt, gap_d;
    logic [TO_W-1:0]  to_cnt, to_d;
    logic             err_d, any_c, own_en_c, abort_c;
    logic [AW-1:0]    addr_c;

    rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req    ({p1.en, p0.en}),
        .last   (last),
        .pick_c (pick_c),
        .any_c  (any_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= port_idx_t'(1'b1);
            gap_cnt     <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            gnt         <= 2'b00;
        end else begin
            state       <= state_d;
            last        <= last_d;
            gap_cnt     <= gap_d;
            to_cnt      <= to_d;
            timeout_err <= err_d;
            gnt         <= {state_d == OWN1, state_d == OWN0};
        end
    end

    // Next state plus the owner mux; a stalled owner is aborted with a fake rdy.
    always_comb begin
        state_d         = state;
        last_d          = last;
        gap_d           = gap_cnt;
        to_d            = to_cnt;
        err_d           = timeout_err;
        own_idx_c       = port_idx_t'(state == OWN1);
        own_en_c        = 1'b0;
        abort_c         = 1'b0;
        addr_c          = '0;
        mem.en          = 1'b0;
        mem.wr          = 1'b0;
        mem.rburst      = 1'b0;
        mem.wburst      = 1'b0;
        mem.wdata       = '0;
        p0.rdy          = 1'b0;
        p0.rdata_load   = 1'b0;
        p1.rdy          = 1'b0;
        p1.rdata_load   = 1'b0;

        unique case (state)
            IDLE: begin
                to_d = '0;
                if (any_c) state_d = pick_c ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
                own_en_c = own_idx_c ? p1.en : p0.en;
                abort_c  = TO_ENABLE && own_en_c && !mem.rdy && (to_cnt == TO_LIMIT);
                if (own_idx_c) begin
                    addr_c        = p1.addr;
                    mem.wr        = p1.wr;
                    mem.rburst    = p1.rburst;
                    mem.wburst    = p1.wburst;
                    mem.wdata     = p1.wdata;
                    p1.rdy        = mem.rdy || abort_c;
                    p1.rdata_load = mem.rdata_load;
                end else begin
                    addr_c        = p0.addr;
                    mem.wr        = p0.wr;
                    mem.rburst    = p0.rburst;
                    mem.wburst    = p0.wburst;
                    mem.wdata     = p0.wdata;
                    p0.rdy        = mem.rdy || abort_c;
                    p0.rdata_load = mem.rdata_load;
                end
                mem.en = own_en_c && !abort_c;
                to_d   = mem.rdy ? '0 : to_cnt + TO_W'(1);
                if (!own_en_c || abort_c) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                    last_d  = own_idx_c;
                end
                if (abort_c) err_d = 1'b1;
            end
            GAP: begin
                to_d = '0;
                if (gap_cnt == '0) state_d = IDLE;
                else               gap_d   = gap_cnt - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.addr  = addr_c;
    assign p0.rdata  = mem.rdata;
    assign p0.rdata0 = mem.rdata0;
    assign p1.rdata  = mem.rdata;
    assign p1.rdata0 = mem.rdata0;

    // Requesters must hold their command fields until the beat is accepted.
    a_p0_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (p0.en && !p0.rdy) |=> (!p0.en || $stable({p0.addr, p0.wr, p0.rburst, p0.wburst, p0.wdata})));
    a_p1_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (p1.en && !p1.rdy) |=> (!p1.en || $stable({p1.addr, p1.wr, p1.rburst, p1.wburst, p1.wdata})));

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench: a cycle table for the basic grant/gap/handoff flow, then
// hand sequences for priority, bursts, timeout abort and mid-burst reset.
module tb_spi_mem_arbiter;
    import spi_mem_pkg::*;

    localparam int unsigned AW    = 24;
    localparam logic [AW-1:0] ADDR0 = 24'h123456;
    localparam logic [AW-1:0] ADDR1 = 24'hABCDEF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_en, p0_rburst, p1_en, p1_rburst, mem_rdy, mem_load;
    logic [7:0] mem_rdata;
    logic [1:0] gnt_a, gnt_b;
    logic       err_a, err_b;
    int         n_chk = 0, n_fail = 0, bad_en = 0;
    int         n_l0, n_l1, n_bad;
    int         own_a[$], own_b[$];
    logic [1:0] prev_a, prev_b;

    spi_mem_arbiter_if #(.AW(AW)) p0a(), p1a(), mema(), p0b(), p1b(), memb();

    assign p0a.addr = ADDR0;     assign p0b.addr = ADDR0;
    assign p0a.en = p0_en;       assign p0b.en = p0_en;
    assign p0a.wr = 1'b0;        assign p0b.wr = 1'b0;
    assign p0a.rburst = p0_rburst; assign p0b.rburst = p0_rburst;
    assign p0a.wburst = 1'b0;    assign p0b.wburst = 1'b0;
    assign p0a.wdata = 8'h3C;    assign p0b.wdata = 8'h3C;
    assign p1a.addr = ADDR1;     assign p1b.addr = ADDR1;
    assign p1a.en = p1_en;       assign p1b.en = p1_en;
    assign p1a.wr = 1'b0;        assign p1b.wr = 1'b0;
    assign p1a.rburst = p1_rburst; assign p1b.rburst = p1_rburst;
    assign p1a.wburst = 1'b0;    assign p1b.wburst = 1'b0;
    assign p1a.wdata = 8'hC3;    assign p1b.wdata = 8'hC3;
    assign mema.rdy = mem_rdy;   assign memb.rdy = mem_rdy;
    assign mema.rdata = mem_rdata;  assign memb.rdata = mem_rdata;
    assign mema.rdata0 = ~mem_rdata; assign memb.rdata0 = ~mem_rdata;
    assign mema.rdata_load = mem_load; assign memb.rdata_load = mem_load;

    spi_mem_arbiter #(.AW(AW), .FIXED_PRIO(1'b0), .GAP_CYCLES(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .p0(p0a), .p1(p1a), .mem(mema),
        .gnt(gnt_a), .timeout_err(err_a));

    spi_mem_arbiter #(.AW(AW), .FIXED_PRIO(1'b1), .GAP_CYCLES(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .p0(p0b), .p1(p1b), .mem(memb),
        .gnt(gnt_b), .timeout_err(err_b));

    always #5 clk = ~clk;

    // mem_en must never be high while no port holds the grant.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && ((mema.en && gnt_a == 2'b00) || (memb.en && gnt_b == 2'b00))) bad_en++;
    end

    typedef struct {
        logic        p0_en, p1_en, rdy, load;
        logic [1:0]  gnt;
        logic        men, r0, r1, l0, l1;
        logic [23:0] addr;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p0_en = 1'b0; p0_rburst = 1'b0; p1_en = 1'b0; p1_rburst = 1'b0;
        mem_rdy = 1'b0; mem_load = 1'b0; mem_rdata = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Row k: inputs driven at a falling edge, outputs checked 1 ns later.
        tbl[0]  = '{1,0,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[1]  = '{1,0,0,0, 2'b01,1,0,0,0,0, ADDR0};
        tbl[2]  = '{1,0,0,0, 2'b01,1,0,0,0,0, ADDR0};
        tbl[3]  = '{1,0,0,0, 2'b01,1,0,0,0,0, ADDR0};
        tbl[4]  = '{1,0,0,0, 2'b01,1,0,0,0,0, ADDR0};
        tbl[5]  = '{1,0,1,1, 2'b01,1,1,0,1,0, ADDR0};
        tbl[6]  = '{0,0,0,0, 2'b01,0,0,0,0,0, ADDR0};
        tbl[7]  = '{0,1,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[8]  = '{0,1,1,1, 2'b00,0,0,0,0,0, 24'h0};
        tbl[9]  = '{0,1,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[10] = '{0,1,1,1, 2'b10,1,0,1,0,1, ADDR1};
        tbl[11] = '{1,0,0,0, 2'b10,0,0,0,0,0, ADDR1};
        tbl[12] = '{1,0,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[13] = '{1,0,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[14] = '{1,0,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[15] = '{1,0,0,0, 2'b01,1,0,0,0,0, ADDR0};
        tbl[16] = '{0,0,0,0, 2'b01,0,0,0,0,0, ADDR0};
        tbl[17] = '{0,0,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[18] = '{0,0,0,0, 2'b00,0,0,0,0,0, 24'h0};
        tbl[19] = '{0,0,0,0, 2'b00,0,0,0,0,0, 24'h0};

        do_reset();
        chk("reset_gnt", 32'(gnt_a), 32'(2'b00));
        chk("reset_err", 32'(err_a), 32'(1'b0));
        chk("reset_men", 32'(mema.en), 32'(1'b0));

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            p0_en = tbl[k].p0_en; p1_en = tbl[k].p1_en;
            mem_rdy = tbl[k].rdy; mem_load = tbl[k].load;
            #1;
            chk($sformatf("vec%0d_ctl", k),
                32'({gnt_a, mema.en, p0a.rdy, p1a.rdy, p0a.rdata_load, p1a.rdata_load}),
                32'({tbl[k].gnt, tbl[k].men, tbl[k].r0, tbl[k].r1, tbl[k].l0, tbl[k].l1}));
            chk($sformatf("vec%0d_addr", k), 32'(mema.addr), 32'(tbl[k].addr));
        end

        // Both ports request from reset and never complete: timeouts rotate the grant.
        do_reset();
        @(negedge clk);
        p0_en = 1'b1; p1_en = 1'b1;
        prev_a = 2'b00; prev_b = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (gnt_a != 2'b00 && prev_a == 2'b00) own_a.push_back(gnt_a == 2'b10 ? 1 : 0);
            if (gnt_b != 2'b00 && prev_b == 2'b00) own_b.push_back(gnt_b == 2'b10 ? 1 : 0);
            prev_a = gnt_a; prev_b = gnt_b;
        end
        chk("rr_grants", 32'(own_a.size()), 32'(4));
        chk("rr_first",  32'(own_a[0]), 32'(0));
        chk("rr_second", 32'(own_a[1]), 32'(1));
        chk("rr_third",  32'(own_a[2]), 32'(0));
        chk("fp_grants", 32'(own_b.size()), 32'(4));
        chk("fp_all_p0", 32'(own_b[0] + own_b[1] + own_b[2] + own_b[3]), 32'(0));

        // Port 1 16-beat read burst; port 0 asks at beat 3 and must wait.
        do_reset();
        @(negedge clk);
        p1_en = 1'b1; p1_rburst = 1'b1;
        n_l0 = 0; n_l1 = 0; n_bad = 0;
        for (int b = 0; b < 16; b++) begin
            for (int ph = 0; ph < 2; ph++) begin
                @(negedge clk);
                mem_rdy = (ph == 0); mem_load = (ph == 0);
                if (b == 3) p0_en = 1'b1;
                #1;
                if (p1a.rdata_load) n_l1++;
                if (p0a.rdata_load || p0a.rdy) n_l0++;
                if (gnt_a != 2'b10) n_bad++;
            end
        end
        chk("burst_p1_loads", 32'(n_l1), 32'(16));
        chk("burst_p0_leak",  32'(n_l0), 32'(0));
        chk("burst_owner",    32'(n_bad), 32'(0));
        @(negedge clk);
        p1_en = 1'b0; p1_rburst = 1'b0; mem_rdy = 1'b0; mem_load = 1'b0;
        #1;
        chk("burst_exit_men", 32'(mema.en), 32'(1'b0));
        chk("burst_exit_gnt", 32'(gnt_a), 32'(2'b10));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("burst_gap%0d", i), 32'({gnt_a, mema.en}), 32'({2'b00, 1'b0}));
        end
        @(negedge clk);
        #1;
        chk("burst_p0_gnt",  32'(gnt_a), 32'(2'b01));
        chk("burst_p0_addr", 32'(mema.addr), 32'(ADDR0));
        chk("burst_p0_men",  32'(mema.en), 32'(1'b1));

        // Stuck port-0 request: abort after 8 owned cycles.
        do_reset();
        @(negedge clk);
        p0_en = 1'b1;
        n_bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            if (!mema.en || gnt_a != 2'b01) n_bad++;
        end
        chk("to_owned_cycles", 32'(n_bad), 32'(0));
        chk("to_wdata", 32'(mema.wdata), 32'(8'h3C));
        @(negedge clk);
        #1;
        chk("to_abort_men", 32'(mema.en), 32'(1'b0));
        chk("to_abort_rdy", 32'(p0a.rdy), 32'(1'b1));
        chk("to_err_pre",   32'(err_a), 32'(1'b0));
        @(negedge clk);
        p0_en = 1'b0;
        #1;
        chk("to_rdy_pulse", 32'(p0a.rdy), 32'(1'b0));
        chk("to_err_set",   32'(err_a), 32'(1'b1));
        chk("to_gap_gnt",   32'(gnt_a), 32'(2'b00));
        repeat (3) @(negedge clk);

        // Reset pulsed in the middle of a port-1 burst.
        @(negedge clk);
        p1_en = 1'b1; p1_rburst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_pre_gnt", 32'(gnt_a), 32'(2'b10));
        chk("to_err_sticky", 32'(err_a), 32'(1'b1));
        @(negedge clk);
        mem_rdy = 1'b1; mem_load = 1'b1; mem_rdata = 8'h5A;
        #1;
        chk("rst_pre_rdy", 32'(p1a.rdy), 32'(1'b1));
        chk("bcast_rdata", 32'({p0a.rdata, p1a.rdata}), 32'(16'h5A5A));
        chk("bcast_rdata0", 32'({p0a.rdata0, p1a.rdata0}), 32'(16'hA5A5));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_men", 32'(mema.en), 32'(1'b0));
        chk("rst_gnt", 32'(gnt_a), 32'(2'b00));
        chk("rst_rdy", 32'({p0a.rdy, p1a.rdy, p0a.rdata_load, p1a.rdata_load}), 32'(4'b0000));
        @(negedge clk);
        p1_en = 1'b0; p1_rburst = 1'b0; mem_rdy = 1'b0; mem_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_state", 32'(dut_a.state), 32'(IDLE));
        chk("rst_err",   32'(err_a), 32'(1'b0));
        chk("rst_gnt_after", 32'(gnt_a), 32'(2'b00));

        chk("en_without_gnt", 32'(bad_en), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
